// File: rtl/gear_pkg.sv
// Shared types and elaboration helpers for the GeAr sequential adder.
package gear_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORR = 2'd1,
        DONE = 2'd2
    } gear_state_t;

    function automatic int gear_k(input int n, input int r, input int p);
        return (n - r - p) / r + 1;
    endfunction

    function automatic bit gear_legal(input int n, input int r, input int p);
        return (r >= 1) && (p >= 1) && (n >= r + p) && (((n - p) % r) == 0);
    endfunction

    // Black prefix cell: combine a higher (g,p) group with the adjacent lower group.
    function automatic logic [1:0] black_cell(input logic g_hi, input logic p_hi,
                                              input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

endpackage

// File: rtl/gear_adder_seq_if.sv
// Operand/result stream between the approximate datapath and the GeAr adder.
interface gear_adder_seq_if #(
    parameter int N  = 16,
    parameter int CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          exact;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  sum;
    logic          cout;
    logic          err_detected;
    logic [CW-1:0] n_corr;

    modport master (
        output in_valid, a, b, exact, out_ready,
        input  in_ready, out_valid, sum, cout, err_detected, n_corr
    );

    modport slave (
        input  in_valid, a, b, exact, out_ready,
        output in_ready, out_valid, sum, cout, err_detected, n_corr
    );
endinterface

// File: rtl/gear_subadder.sv
// W-bit Kogge-Stone prefix adder with carry-in 0; also reports group propagate
// of its low P bits, which the top uses to flag carry-speculation misses.
module gear_subadder
    import gear_pkg::*;
#(
    parameter int W = 8,
    parameter int P = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         grp_p
);
    localparam int L = $clog2(W);

    logic [W-1:0] p0;
    logic [W-1:0] gl;
    logic [W-1:0] pl;
    logic [W-1:0] gn;
    logic [W-1:0] pn;

    always_comb begin
        p0 = a ^ b;
        gl = a & b;
        pl = a ^ b;
        gn = gl;
        pn = pl;
        for (int l = 0; l < L; l++) begin
            gn = gl;
            pn = pl;
            for (int i = (1 << l); i < W; i++) begin
                {gn[i], pn[i]} = black_cell(gl[i], pl[i], gl[i-(1<<l)], pl[i-(1<<l)]);
            end
            gl = gn;
            pl = pn;
        end
    end

    // After the last level gl[i] / pl[i] cover bits [i:0].
    assign sum   = p0 ^ {gl[W-2:0], 1'b0};
    assign cout  = gl[W-1];
    assign grp_p = pl[P-1];

endmodule

// File: rtl/gear_adder_seq.sv
// Sequential GeAr adder: speculative sum in one cycle, optional iterative
// correction of the lowest mis-speculated sub-adder, one per cycle.
//
// state | meaning
// IDLE  | in_ready high; accept operands, latch approximate sum and error flag
// CORR  | correct lowest uncorrected erroneous sub-adder, or finish
// DONE  | out_valid high; result held until out_ready
module gear_adder_seq
    import gear_pkg::*;
#(
    parameter int N = 16,
    parameter int R = 4,
    parameter int P = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    gear_adder_seq_if.slave  bus
);
    localparam int K  = gear_k(N, R, P);
    localparam int W  = R + P;
    localparam int CW = $clog2(K) + 1;

    if (!gear_legal(N, R, P)) begin : g_bad_params
        $error("gear_adder_seq: illegal N/R/P combination");
    end

    gear_state_t   state, state_n;
    logic [N-1:0]  a_q, a_n, b_q, b_n;
    logic [N-1:0]  s_q, s_n;
    logic          cout_q, cout_n;
    logic          errd_q, errd_n;
    logic [CW-1:0] nc_q, nc_n;
    logic [K-1:0]  mask_q, mask_n;

    logic [N-1:0]          op_a, op_b;
    logic [K-1:0][W-1:0]   sub_sum;
    logic [K-1:0]          sub_cout;
    logic [K-1:0]          sub_gp;
    logic [N-1:0]          approx_sum;
    logic                  approx_cout;
    logic [N-1:0]          s_chk;
    logic [K-1:0]          err, live;
    logic [CW-1:0]         sel;
    logic                  any_live;
    logic                  unused_bits;

    // In IDLE the sub-adders see the incoming operands; afterwards the held ones.
    assign op_a = (state == IDLE) ? bus.a : a_q;
    assign op_b = (state == IDLE) ? bus.b : b_q;

    for (genvar j = 0; j < K; j++) begin : g_sub
        gear_subadder #(.W(W), .P(P)) u_sub (
            .a     (op_a[j*R +: W]),
            .b     (op_b[j*R +: W]),
            .sum   (sub_sum[j]),
            .cout  (sub_cout[j]),
            .grp_p (sub_gp[j])
        );
    end

    assign unused_bits = ^{sub_sum, sub_cout, sub_gp};

    always_comb begin
        approx_sum        = '0;
        approx_sum[W-1:0] = sub_sum[0];
        for (int j = 1; j < K; j++) begin
            approx_sum[j*R+P +: R] = sub_sum[j][P +: R];
        end
        approx_cout = sub_cout[K-1];
    end

    always_comb begin
        s_chk    = (state == IDLE) ? approx_sum : s_q;
        err      = '0;
        for (int j = 1; j < K; j++) begin
            err[j] = sub_gp[j] & (op_a[j*R] ^ op_b[j*R] ^ s_chk[j*R]);
        end
        // A corrected sub-adder keeps its flag (bit jR is untouched), so mask it.
        live     = err & ~mask_q;
        sel      = '0;
        any_live = 1'b0;
        for (int j = K - 1; j >= 1; j--) begin
            if (live[j]) begin
                sel      = CW'(j);
                any_live = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        s_n     = s_q;
        cout_n  = cout_q;
        errd_n  = errd_q;
        nc_n    = nc_q;
        mask_n  = mask_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    a_n     = bus.a;
                    b_n     = bus.b;
                    s_n     = approx_sum;
                    cout_n  = approx_cout;
                    errd_n  = |err;
                    nc_n    = '0;
                    mask_n  = '0;
                    state_n = bus.exact ? CORR : DONE;
                end
            end
            CORR: begin
                if (any_live) begin
                    for (int j = 1; j < K; j++) begin
                        if (CW'(j) == sel) begin
                            if (j == K - 1) begin
                                {cout_n, s_n[j*R+P +: R]} = {cout_q, s_q[j*R+P +: R]} + (R+1)'(1);
                            end else begin
                                s_n[j*R+P +: R] = s_q[j*R+P +: R] + R'(1);
                            end
                        end
                        if (CW'(j) <= sel) begin
                            mask_n[j] = 1'b1;
                        end
                    end
                    nc_n = nc_q + CW'(1);
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            errd_q <= 1'b0;
            nc_q   <= '0;
            mask_q <= '0;
        end else begin
            state  <= state_n;
            a_q    <= a_n;
            b_q    <= b_n;
            s_q    <= s_n;
            cout_q <= cout_n;
            errd_q <= errd_n;
            nc_q   <= nc_n;
            mask_q <= mask_n;
        end
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = (state == DONE);
    assign bus.sum          = s_q;
    assign bus.cout         = cout_q;
    assign bus.err_detected = errd_q;
    assign bus.n_corr       = nc_q;

endmodule

// File: tb/tb_gear_adder_seq.sv
// Directed and random checks of gear_adder_seq with N=16, R=4, P=4 (K=3).
module tb_gear_adder_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gear_adder_seq_if #(.N(16), .CW(3)) bus();

    gear_adder_seq #(.N(16), .R(4), .P(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ex;
        logic [15:0] s;
        logic        c;
        logic        e;
        logic [2:0]  n;
        int          lat;
    } vec_t;

    // Independent window model of the speculative sum: {cout, sum}.
    function automatic logic [16:0] approx_model(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic [8:0]  w;
        r = '0;
        w = {1'b0, a[7:0]}  + {1'b0, b[7:0]};
        r[7:0] = w[7:0];
        w = {1'b0, a[11:4]} + {1'b0, b[11:4]};
        r[11:8] = w[7:4];
        w = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        r[15:12] = w[7:4];
        r[16] = w[8];
        return r;
    endfunction

    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic ex, output int lat);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.exact    = ex;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.sum !== 16'h0000)    begin errors++; $display("FAIL rst_sum got %h want 0000", bus.sum); end
        checks++; if (bus.cout !== 1'b0)       begin errors++; $display("FAIL rst_cout got %b want 0", bus.cout); end
        checks++; if (bus.err_detected !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.err_detected); end
        checks++; if (bus.n_corr !== 3'd0)     begin errors++; $display("FAIL rst_n_corr got %0d want 0", bus.n_corr); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_idle got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        vec_t vt[6];
        int   lat;
        vt[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 3'd0, 1};
        vt[1] = '{16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b0, 1'b0, 3'd0, 2};
        vt[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 1};
        vt[3] = '{16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b1, 3'd1, 3};
        vt[4] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 3'd2, 4};
        vt[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFF00, 1'b0, 1'b1, 3'd0, 1};
        for (int i = 0; i < 6; i++) begin
            run_txn(vt[i].a, vt[i].b, vt[i].ex, lat);
            checks++; if (lat !== vt[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, vt[i].lat); end
            checks++; if (bus.sum !== vt[i].s) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, bus.sum, vt[i].s); end
            checks++; if (bus.cout !== vt[i].c) begin errors++; $display("FAIL dir%0d_cout got %b want %b", i, bus.cout, vt[i].c); end
            checks++; if (bus.err_detected !== vt[i].e) begin errors++; $display("FAIL dir%0d_err got %b want %b", i, bus.err_detected, vt[i].e); end
            checks++; if (bus.n_corr !== vt[i].n) begin errors++; $display("FAIL dir%0d_n_corr got %0d want %0d", i, bus.n_corr, vt[i].n); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_txn(16'h00FF, 16'h0001, 1'b1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", lat); end
        bus.a        = 16'hAAAA;
        bus.b        = 16'h5555;
        bus.exact    = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d_hs got vld=%b rdy=%b want 1 0", c, bus.out_valid, bus.in_ready);
            end
            checks++; if (bus.sum !== 16'h0100 || bus.cout !== 1'b0 || bus.n_corr !== 3'd1 || bus.err_detected !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d_data got %h c=%b n=%0d e=%b want 0100 0 1 1", c, bus.sum, bus.cout, bus.n_corr, bus.err_detected);
            end
        end
        bus.in_valid = 1'b0;
        consume();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL bp_no_accept%0d got vld=%b rdy=%b want 0 1", c, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        bus.a        = 16'hFFFF;
        bus.b        = 16'h0001;
        bus.exact    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_busy got rdy=%b vld=%b want 0 0", bus.in_ready, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_hs got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        checks++; if (bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.err_detected !== 1'b0 || bus.n_corr !== 3'd0) begin
            errors++; $display("FAIL mid_rst_data got %h c=%b e=%b n=%0d want 0000 0 0 0", bus.sum, bus.cout, bus.err_detected, bus.n_corr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL mid_after%0d got vld=%b rdy=%b want 0 1", c, bus.out_valid, bus.in_ready);
            end
        end
        run_txn(16'h1234, 16'h1111, 1'b1, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mid_next_latency got %0d want 2", lat); end
        checks++; if (bus.sum !== 16'h2345 || bus.cout !== 1'b0 || bus.n_corr !== 3'd0) begin
            errors++; $display("FAIL mid_next_data got %h c=%b n=%0d want 2345 0 0", bus.sum, bus.cout, bus.n_corr);
        end
        consume();
    endtask

    task automatic test_random_exact();
        int          lat;
        logic [15:0] a, b;
        logic [16:0] want, apx;
        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 4 == 0) b = ~a + 16'($urandom_range(0, 3));
            run_txn(a, b, 1'b1, lat);
            want = {1'b0, a} + {1'b0, b};
            apx  = approx_model(a, b);
            checks++; if ({bus.cout, bus.sum} !== want) begin
                errors++; $display("FAIL rnd_exact_sum a=%h b=%h got %h want %h", a, b, {bus.cout, bus.sum}, want);
            end
            checks++; if ($isunknown(bus.n_corr) || bus.n_corr > 3'd2) begin
                errors++; $display("FAIL rnd_exact_n_corr a=%h b=%h got %0d want <=2", a, b, bus.n_corr);
            end
            checks++; if (lat !== 2 + int'(bus.n_corr)) begin
                errors++; $display("FAIL rnd_exact_latency a=%h b=%h got %0d want %0d", a, b, lat, 2 + int'(bus.n_corr));
            end
            checks++; if (bus.err_detected !== (apx != want)) begin
                errors++; $display("FAIL rnd_exact_err a=%h b=%h got %b want %b", a, b, bus.err_detected, (apx != want));
            end
            consume();
        end
    endtask

    task automatic test_random_approx();
        int          lat;
        logic [15:0] a, b;
        logic [16:0] want, apx;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 3 == 0) b = ~a + 16'($urandom_range(0, 2));
            run_txn(a, b, 1'b0, lat);
            want = {1'b0, a} + {1'b0, b};
            apx  = approx_model(a, b);
            checks++; if ({bus.cout, bus.sum} !== apx) begin
                errors++; $display("FAIL rnd_apx_sum a=%h b=%h got %h want %h", a, b, {bus.cout, bus.sum}, apx);
            end
            checks++; if (bus.err_detected !== (apx != want)) begin
                errors++; $display("FAIL rnd_apx_err a=%h b=%h got %b want %b", a, b, bus.err_detected, (apx != want));
            end
            checks++; if (bus.n_corr !== 3'd0 || lat !== 1) begin
                errors++; $display("FAIL rnd_apx_timing a=%h b=%h got n=%0d lat=%0d want 0 1", a, b, bus.n_corr, lat);
            end
            consume();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.exact     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random_exact();
        test_random_approx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
